// File: rtl/sort_pkt_checker_pkg.sv
// sort_pkt_checker_pkg: FSM states, LFSR constants and the packet report record shared by the checker.
package sort_pkt_checker_pkg;
    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int RPT_LW = 32;
    localparam int RPT_SW = 64;
    typedef struct packed {
        logic [RPT_LW-1:0] len;
        logic [RPT_SW-1:0] sum;
        logic              order_err;
        logic              framing_err;
        logic              len_err;
    } report_t;
endpackage

// File: rtl/sort_pkt_lfsr.sv
// sort_pkt_lfsr: 16-bit Fibonacci LFSR for sink backpressure, present only with SORT_PKT_CHECKER_BACKPRESSURE_EN.
`ifdef SORT_PKT_CHECKER_BACKPRESSURE_EN
module sort_pkt_lfsr
    import sort_pkt_checker_pkg::*;
(
    input  logic        clk,
    input  logic        srst_n,
    output logic [15:0] lfsr
);
    always_ff @(posedge clk)
        lfsr <= !srst_n ? LFSR_SEED : {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
endmodule
`endif

// File: rtl/sort_pkt_checker.sv
// sort_pkt_checker: checks a sorted Avalon-ST packet stream and reports length, sum and errors; SORT_PKT_CHECKER_BACKPRESSURE_EN adds LFSR backpressure.
module sort_pkt_checker
    import sort_pkt_checker_pkg::*;
#(
    parameter  int DWIDTH      = 8,
    parameter  int MAX_PKT_LEN = 1024,
    localparam int LW          = $clog2(MAX_PKT_LEN + 1),
    localparam int SW          = DWIDTH + LW
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic              pkt_done_o,
    output logic [LW-1:0]     pkt_len_o,
    output logic [SW-1:0]     pkt_sum_o,
    output logic              order_err_o,
    output logic              framing_err_o,
    output logic              len_err_o,
    output logic [15:0]       pkt_cnt_o,
    output logic              err_sticky_o
);
    state_t            state, state_n;
    logic [LW-1:0]     len, len_n;
    logic [SW-1:0]     sum, sum_n;
    logic [DWIDTH-1:0] prev, prev_n;
    logic              ord, ord_n, ovf, ovf_n, done, done_n, sticky, sticky_n;
    report_t           rpt, rpt_n;
    logic [15:0]       cnt;
    logic              beat, full, unused_rpt;
`ifdef SORT_PKT_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr;
    sort_pkt_lfsr u_lfsr (.clk(clk_i), .srst_n(srst_n_i), .lfsr(lfsr));
    assign snk_ready_o = srst_n_i & (lfsr[0] | lfsr[1]);
`else
    assign snk_ready_o = srst_n_i;
`endif
    assign beat = snk_valid_i & snk_ready_o;
    assign full = len == LW'(MAX_PKT_LEN);
    always_comb begin
        state_n  = state;
        len_n    = len;
        sum_n    = sum;
        prev_n   = prev;
        ord_n    = ord;
        ovf_n    = ovf;
        done_n   = 1'b0;
        rpt_n    = rpt;
        sticky_n = sticky;
        if (beat) begin
            if (snk_startofpacket_i) begin
                if (state != IDLE) begin
                    done_n = 1'b1;
                    rpt_n  = '{RPT_LW'(len), RPT_SW'(sum), ord, 1'b1, ovf};
                end else if (snk_endofpacket_i) begin
                    done_n = 1'b1;
                    rpt_n  = '{RPT_LW'(1), RPT_SW'(snk_data_i), 1'b0, 1'b0, 1'b0};
                end
                // A sop+eop beat that also closes a broken packet only yields the framing report.
                len_n   = LW'(1);
                sum_n   = SW'(snk_data_i);
                prev_n  = snk_data_i;
                ord_n   = 1'b0;
                ovf_n   = 1'b0;
                state_n = snk_endofpacket_i ? IDLE : BODY;
            end else if (state == IDLE) begin
                sticky_n = 1'b1;
            end else begin
                if (state == BODY) begin
                    ovf_n  = full;
                    len_n  = full ? len : len + LW'(1);
                    sum_n  = full ? sum : sum + SW'(snk_data_i);
                    ord_n  = full ? ord : ord | (snk_data_i < prev);
                    prev_n = full ? prev : snk_data_i;
                end
                state_n = snk_endofpacket_i ? IDLE : (ovf_n ? DROP : BODY);
                if (snk_endofpacket_i) begin
                    done_n = 1'b1;
                    rpt_n  = '{RPT_LW'(len_n), RPT_SW'(sum_n), ord_n, 1'b0, ovf_n};
                end
            end
        end
        if (done_n)
            sticky_n = sticky_n | rpt_n.order_err | rpt_n.framing_err | rpt_n.len_err;
    end
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state  <= IDLE;
            len    <= '0;
            sum    <= '0;
            prev   <= '0;
            ord    <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            rpt    <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            len    <= len_n;
            sum    <= sum_n;
            prev   <= prev_n;
            ord    <= ord_n;
            ovf    <= ovf_n;
            done   <= done_n;
            rpt    <= rpt_n;
            sticky <= sticky_n;
            cnt    <= cnt + 16'(done_n);
        end
    end
    assign unused_rpt    = ^{rpt.len[RPT_LW-1:LW], rpt.sum[RPT_SW-1:SW]};
    assign pkt_done_o    = done;
    assign pkt_len_o     = rpt.len[LW-1:0];
    assign pkt_sum_o     = rpt.sum[SW-1:0];
    assign order_err_o   = rpt.order_err;
    assign framing_err_o = rpt.framing_err;
    assign len_err_o     = rpt.len_err;
    assign pkt_cnt_o     = cnt;
    assign err_sticky_o  = sticky;
endmodule

// File: doc/sort_pkt_checker.md
SORT_PKT_CHECKER -- requirements
Module: sort_pkt_checker

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, width of one data beat.
REQ-002 SHALL have parameter MAX_PKT_LEN, default 1024, maximum legal beats per packet; LW = $clog2(MAX_PKT_LEN+1).
REQ-003 SHALL have port clk_i input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port srst_n_i input 1: synchronous, active-low reset.
REQ-005 SHALL have ports snk_data_i input DWIDTH, snk_startofpacket_i input 1, snk_endofpacket_i input 1, snk_valid_i input 1: Avalon-ST sink carrying the sort block's output stream.
REQ-006 SHALL have port snk_ready_o output 1: sink ready.
REQ-007 SHALL have ports pkt_done_o output 1 (one-cycle packet-report strobe), pkt_len_o output LW (beats in reported packet), pkt_sum_o output DWIDTH+LW (sum of reported packet's beats).
REQ-008 SHALL have ports order_err_o, framing_err_o, len_err_o, each output 1: status of the reported packet, valid only while pkt_done_o=1.
REQ-009 SHALL have ports pkt_cnt_o output 16 (reported packets, wraps 0xFFFF->0) and err_sticky_o output 1 (set by any error, cleared only by reset).

Function
REQ-010 SHALL define a beat as a cycle with snk_valid_i=1 and snk_ready_o=1; other cycles SHALL leave state unchanged.
REQ-011 SHALL implement FSM states IDLE, BODY, DROP; reset state IDLE.
REQ-012 IDLE, beat with sop: len=1, sum=data, prev=data; eop also set -> report, stay IDLE; else -> BODY.
REQ-013 IDLE, beat without sop: beat discarded, err_sticky_o set, no report, stay IDLE.
REQ-014 BODY, beat without sop: len+1, sum+data; data < prev (unsigned) sets packet order flag; prev=data; eop -> report, IDLE.
REQ-015 BODY, beat with sop: report current packet with framing_err_o=1, then start new packet from this beat as in REQ-012 in the same cycle.
REQ-016 BODY, beat that would make len exceed MAX_PKT_LEN: set len flag, len saturates at MAX_PKT_LEN, sum stops, -> DROP.
REQ-017 DROP: beats discarded; eop beat -> report with len_err_o=1, IDLE; sop beat -> as REQ-015.
REQ-018 Report: pkt_done_o, pkt_len_o, pkt_sum_o, error outputs SHALL be registered and present in the cycle after the closing beat; pkt_cnt_o increments in that same cycle.
REQ-019 pkt_sum_o SHALL be the exact unsigned sum, no overflow at DWIDTH+LW bits.
REQ-020 Without the configuration macro, snk_ready_o SHALL be 1 in every cycle after reset release.

Reset
REQ-021 While srst_n_i=0: snk_ready_o=0, pkt_done_o=0, all error outputs 0, pkt_len_o=0, pkt_sum_o=0, pkt_cnt_o=0, err_sticky_o=0, FSM IDLE.
REQ-022 Reset mid-packet SHALL discard the partial packet without a report.

Configuration
REQ-023 Macro SORT_PKT_CHECKER_BACKPRESSURE_EN defined: snk_ready_o = lfsr[0] | lfsr[1] of a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 at reset, advancing every cycle; not defined: REQ-020 applies and no LFSR is built.

Structure
REQ-024 Package sort_pkt_checker_pkg SHALL hold the FSM state enum, the LFSR seed and tap constants, and the report struct (len, sum, three error flags).
REQ-025 Sub-module sort_pkt_lfsr SHALL hold the LFSR, instantiated only under the macro.

Verification
REQ-026 Packet {3,7,7,200}, valid continuous -> one pulse: len 4, sum 217, no errors, pkt_cnt_o 1.
REQ-027 Packet {10,5,6} -> order_err_o=1, len 3, sum 21, err_sticky_o=1 afterwards.
REQ-028 Single beat with sop+eop, data 0xFF -> len 1, sum 255, no errors.
REQ-029 sop,1,2, then sop,4,eop -> first report len 3 framing_err_o=1, second report len 2 sum 4, no errors.
REQ-030 MAX_PKT_LEN=4, 6-beat packet -> one report len 4, len_err_o=1, sum of first 4 beats.
REQ-031 Reset asserted after 2 beats, then clean 2-beat packet {1,2} -> only one report, len 2, pkt_cnt_o 1; with macro, rerun REQ-026 and REQ-029 with gaps valid=0 and ready low, same results.
